// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streaming adapter.
package fifo_pkg;

   localparam int unsigned RD_STREAM_DEPTH = 2;
   localparam int unsigned FIFO_DATA_WIDTH = 8;

   typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail buffer with push, pop and flush; reports its occupancy.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output occ_t                  occ
);

   logic [DATA_WIDTH-1:0] tail;
   logic [DATA_WIDTH-1:0] head_next;
   logic [DATA_WIDTH-1:0] tail_next;
   occ_t                  occ_after_pop;
   occ_t                  occ_next;

   always_comb begin
      head_next     = head;
      tail_next     = tail;
      occ_after_pop = occ - occ_t'(pop);
      occ_next      = occ_after_pop + occ_t'(push);
      if (pop && occ == occ_t'(RD_STREAM_DEPTH))
         head_next = tail;
      // A push into a buffer that is empty after this pop bypasses the tail.
      if (push) begin
         if (occ_after_pop == '0)
            head_next = push_data;
         else
            tail_next = push_data;
      end
      if (flush)
         occ_next = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         head <= head_next;
         tail <= tail_next;
         occ  <= occ_next;
      end
   end

   occ_never_overflows: assert property (
      @(posedge clk) disable iff (rst) occ_next <= occ_t'(RD_STREAM_DEPTH));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-domain drain adapter: pops the FIFO on credit and streams entries out.
// Optional beat counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
`ifdef FIFO_RD_STREAM_CNT_EN
   , parameter int unsigned CNT_WIDTH = 16
`endif
) (
   input  logic                  rd_clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   input  logic                  fifo_empty_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o
`ifdef FIFO_RD_STREAM_CNT_EN
   , output logic [CNT_WIDTH-1:0] beat_cnt_o
`endif
);

   occ_t occ;
   occ_t credit;
   logic inflight;
   logic pop;

   assign m_valid_o = (occ != '0);
   assign pop       = m_valid_o && m_ready_i;

   // Slots committed after this edge; pop implies occ >= 1 so no underflow.
   assign credit       = occ + occ_t'(inflight) - occ_t'(pop);
   assign fifo_rd_en_o = !fifo_empty_i && !flush_i &&
                         (credit < occ_t'(RD_STREAM_DEPTH));

   always_ff @(posedge rd_clk_i or posedge rst_i) begin
      if (rst_i)
         inflight <= 1'b0;
      else
         inflight <= fifo_rd_en_o;
   end

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (rd_clk_i),
      .rst       (rst_i),
      .flush     (flush_i),
      .push      (inflight && !flush_i),
      .push_data (fifo_rdata_i),
      .pop       (pop),
      .head      (m_data_o),
      .occ       (occ)
   );

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge rd_clk_i or posedge rst_i) begin
      if (rst_i)
         beat_cnt_o <= '0;
      else if (pop)
         beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);
   end
`endif

   never_read_empty: assert property (
      @(posedge rd_clk_i) disable iff (rst_i) !(fifo_rd_en_o && fifo_empty_i));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port model.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       rd_en;
   logic       empty;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] rdata;
   logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
   localparam int CW = 4;
   logic [CW-1:0] beat_cnt;
`endif

   logic [7:0] mem [0:511];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int rd_err = 0;
   int n_cmp = 0;
   int n_err = 0;
   int exp_beats = 0;
   int reads;
   int max_occ;
   logic [7:0] exp_q [$];
   logic [7:0] d;

   always #5 clk = ~clk;

   fifo_rd_stream #(
      .DATA_WIDTH (8)
`ifdef FIFO_RD_STREAM_CNT_EN
      , .CNT_WIDTH (CW)
`endif
   ) u_dut (
      .rd_clk_i     (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .fifo_rd_en_o (rd_en),
      .fifo_rdata_i (rdata),
      .fifo_empty_i (empty),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
      , .beat_cnt_o (beat_cnt)
`endif
   );

   // FIFO read port: registered rdata, empty follows the word counts.
   assign empty = (wr_cnt == rd_cnt);

   always @(posedge clk or posedge rst) begin
      if (rst)
         rdata <= '0;
      else if (rd_en) begin
         if (empty)
            rd_err <= rd_err + 1;
         else begin
            rdata  <= mem[rd_cnt % 512];
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] val);
      mem[wr_cnt % 512] = val;
      wr_cnt++;
   endtask

   task automatic check_cnt(input string tag);
`ifdef FIFO_RD_STREAM_CNT_EN
      check(tag, 32'(beat_cnt), 32'(exp_beats % (1 << CW)));
`else
      check(tag, 32'(rd_err), 32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
      #1;
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data",  32'(m_data),  32'd0);
      check("rst_rden",  32'(rd_en),   32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle with empty FIFO
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_rden",  32'(rd_en),   32'd0);
         check("idle_valid", 32'(m_valid), 32'd0);
      end
      check("idle_rderr", 32'(rd_err), 32'd0);

      // Throughput: 16 beats, no gaps
      @(negedge clk);
      m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) push(8'(i));
      #1;
      check("tp_rden_n", 32'(rd_en), 32'd1);
      @(negedge clk);
      check("tp_valid_n1", 32'(m_valid), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check("tp_valid", 32'(m_valid), 32'd1);
         check("tp_data",  32'(m_data),  32'(i));
      end
      exp_beats += 16;
      @(negedge clk);
      check("tp_drained", 32'(m_valid), 32'd0);
      check_cnt("tp_beat_cnt");

      // Backpressure: 4 words in FIFO, only 2 reads issue
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h21 + i));
      reads = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (rd_en) reads++;
         if (i >= 2) begin
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_hold",  32'(m_data),  32'h21);
         end
      end
      check("bp_reads",    32'(reads),           32'd2);
      check("bp_fifo_occ", 32'(wr_cnt - rd_cnt), 32'd2);
      @(negedge clk);
      m_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check("bp_rel_valid", 32'(m_valid), 32'd1);
         check("bp_rel_data",  32'(m_data),  32'(8'h21 + j));
         @(negedge clk);
      end
      exp_beats += 4;
      check("bp_drained", 32'(m_valid), 32'd0);

      // Random ready, 200 random words
      m_ready = 1'b0;
      max_occ = 0;
      for (int i = 0; i < 200; i++) begin
         d = 8'($urandom);
         push(d);
         exp_q.push_back(d);
      end
      for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         if (int'(u_dut.u_skid.occ) > max_occ) max_occ = int'(u_dut.u_skid.occ);
         if (m_valid && m_ready) begin
            check("rnd_data", 32'(m_data), 32'(exp_q.pop_front()));
            exp_beats++;
         end
      end
      check("rnd_all_out", 32'(exp_q.size()), 32'd0);
      check("rnd_occ_le2", 32'(max_occ <= 2), 32'd1);
      check("rnd_rderr",   32'(rd_err),       32'd0);
      check_cnt("rnd_beat_cnt");

      // Flush with a full buffer
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
      repeat (3) @(negedge clk);
      check("fl_occ2",  32'(u_dut.u_skid.occ), 32'd2);
      check("fl_head",  32'(m_data), 32'h31);
      flush = 1'b1;
      #1;
      check("fl_rden",  32'(rd_en), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      m_ready = 1'b1;
      check("fl_valid_after", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("fl_valid_gap", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("fl_next_valid", 32'(m_valid), 32'd1);
      check("fl_next_data",  32'(m_data),  32'h33);
      @(negedge clk);
      check("fl_next_data2", 32'(m_data),  32'h34);
      @(negedge clk);
      check("fl_drained", 32'(m_valid), 32'd0);
      exp_beats += 2;

      // Flush drops an in-flight read
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(8'(8'h41 + i));
      #1;
      check("fi_rden", 32'(rd_en), 32'd1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("fi_rden_flush", 32'(rd_en), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      m_ready = 1'b1;
      check("fi_valid0", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("fi_valid1", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("fi_data42", 32'(m_data), 32'h42);
      check("fi_valid2", 32'(m_valid), 32'd1);
      @(negedge clk);
      check("fi_data43", 32'(m_data), 32'h43);
      @(negedge clk);
      check("fi_drained", 32'(m_valid), 32'd0);
      exp_beats += 2;
      check_cnt("fi_beat_cnt");
      check("fi_rderr", 32'(rd_err), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
      repeat (4) @(negedge clk);
      check("ar_valid_pre", 32'(m_valid), 32'd1);
      #2;
      rst = 1'b1;
      wr_cnt = rd_cnt;
      #1;
      exp_beats = 0;
      check("ar_valid", 32'(m_valid), 32'd0);
      check("ar_data",  32'(m_data),  32'd0);
      check("ar_rden",  32'(rd_en),   32'd0);
      check_cnt("ar_beat_cnt");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ar_post_valid", 32'(m_valid), 32'd0);
      check("ar_post_rden",  32'(rd_en),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
